// File: rtl/shift_unit_pkg.sv
// shift_pkg -- shared definitions for the shift_unit block.
//   OP_*      : operation encodings carried on the 3-bit op field
//   state_e   : FSM state encoding (IDLE / SHIFT / DONE)
//   WIDTH_DEF / SHAMT_W_DEF : default data path and shift amount widths
// OP_ROR / OP_ROL only take effect when SHIFT_UNIT_ROTATE_EN is defined.
package shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_SLL  = 3'b001,
    OP_SRL  = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_unit_if.sv
// shift_unit_if -- request/result bundle for shift_unit.
//   start    : operation request (master -> slave)
//   op       : 3-bit op code, raw so undefined codes can be driven
//   shamt    : shift amount
//   data_in  : operand
//   busy     : unit not idle (slave -> master)
//   done     : one-cycle completion pulse
//   data_out : result register
interface shift_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   data_out;

  modport master (output start, op, shamt, data_in, input busy, done, data_out);
  modport slave  (input start, op, shamt, data_in, output busy, done, data_out);
endinterface

// File: rtl/shift_unit_step.sv
// shift_step -- combinational single-bit shift/rotate of i_data by i_op.
//   i_data : current value
//   i_op   : latched op code
//   o_data : value after one step
// Rotates exist only with SHIFT_UNIT_ROTATE_EN; otherwise every code other
// than SLL/SRL/SRA passes the data through unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_data
);
  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_SLL: o_data = {i_data[WIDTH-2:0], 1'b0};
      OP_SRL: o_data = {1'b0, i_data[WIDTH-1:1]};
      OP_SRA: o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR: o_data = {i_data[0], i_data[WIDTH-1:1]};
      OP_ROL: o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
`endif
      default: o_data = i_data;
    endcase
  end
endmodule

// File: rtl/shift_unit.sv
// shift_unit -- multi-cycle shifter, one bit per cycle.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset, overrides start
//   bus   : shift_unit_if.slave (start/op/shamt/data_in in, busy/done/data_out out)
// Optional feature: SHIFT_UNIT_ROTATE_EN adds OP_ROR / OP_ROL.
// Latency for shamt = k is k+1 cycles; shamt = 0 goes straight to DONE.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  shift_unit_if.slave bus
);
  state_e             r_state;
  state_e             w_next_state;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2:0]         r_op_q;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_step;
  logic               w_busy;
  logic               w_done;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_data (r_data),
    .i_op   (r_op_q),
    .o_data (w_step)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // next state; SHIFT exits on the cycle applying the last step (cnt == 1)
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = (bus.shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (r_cnt == SHAMT_W'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    w_busy = (r_state != IDLE);
    w_done = (r_state == DONE);
  end

  // datapath: operands latch only in IDLE, so starts while busy are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_op_q <= OP_PASS;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_data <= bus.data_in;
          r_cnt  <= bus.shamt;
          r_op_q <= bus.op;
        end
        SHIFT: begin
          r_data <= w_step;
          r_cnt  <= r_cnt - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.data_out = r_data;
endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
  shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  // result of applying op j times to d, from closed-form arithmetic
  function automatic logic [31:0] ref_f(input logic [31:0] d, input logic [2:0] op, input int j);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      3'b001: return d << j;
      3'b010: return d >> j;
      3'b011: return 32'($signed(d) >>> j);
`ifdef SHIFT_UNIT_ROTATE_EN
      3'b100: return dd[31:0] >> 0 == 0 ? 32'(dd >> j) : 32'(dd >> j);
      3'b101: return 32'((dd << j) >> 32);
`endif
      default: return d;
    endcase
  endfunction

  // model: an accepted op is active for k+1 cycles, j = steps applied so far
  logic        m_valid  = 1'b0;
  logic        m_active = 1'b0;
  int          m_j = 0, m_k = 0;
  logic [31:0] m_d = '0, m_hold = '0;
  logic [2:0]  m_op = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_hold   <= '0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active <= 1'b1;
        m_j      <= 0;
        m_k      <= int'(bus.shamt);
        m_d      <= bus.data_in;
        m_op     <= bus.op;
      end
    end else if (m_j == m_k) begin
      m_active <= 1'b0;
      m_hold   <= ref_f(m_d, m_op, m_k);
    end else begin
      m_j <= m_j + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [31:0] e_data;
      logic        e_busy, e_done;
      e_data = m_active ? ref_f(m_d, m_op, m_j) : m_hold;
      e_busy = m_active;
      e_done = m_active && (m_j == m_k);
      n_vec++;
      if (bus.data_out !== e_data || bus.busy !== e_busy || bus.done !== e_done) begin
        n_err++;
        $display("FAIL cycle_model t=%0t: data=%h busy=%b done=%b, required data=%h busy=%b done=%b",
                 $time, bus.data_out, bus.busy, bus.done, e_data, e_busy, e_done);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge of cycle 1
  task automatic do_start(input logic [2:0] op, input int sh, input logic [31:0] d);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.shamt   = 5'(sh);
    bus.data_in = d;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // cyc0 = current cycle number relative to the start edge; returns when idle
  task automatic wait_done(input int cyc0, input logic [31:0] exp, input int lat, input string name);
    int cyc;
    cyc = cyc0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_lat"}, 32'(cyc), 32'(lat));
    check({name, "_data"}, bus.data_out, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ror_exp;
    bus.start = 1'b0; bus.op = '0; bus.shamt = '0; bus.data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_data", bus.data_out, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_start(3'b001, 4, 32'h0000_0001);
    check("sll4_busy_c1", 32'(bus.busy), 32'h1);
    wait_done(1, 32'h0000_0010, 5, "sll4");

    do_start(3'b011, 31, 32'h8000_0000);
    wait_done(1, 32'hFFFF_FFFF, 32, "sra31");
    do_start(3'b010, 31, 32'h8000_0000);
    wait_done(1, 32'h0000_0001, 32, "srl31");
    do_start(3'b001, 31, 32'h0000_0001);
    wait_done(1, 32'h8000_0000, 32, "sll31");

    for (int o = 0; o < 4; o++) begin
      do_start(3'(o), 0, 32'h1234_ABCD);
      wait_done(1, 32'h1234_ABCD, 1, "sh0");
    end

    do_start(3'b111, 3, 32'hA5A5_A5A5);
    wait_done(1, 32'hA5A5_A5A5, 4, "undef_op");

`ifdef SHIFT_UNIT_ROTATE_EN
    ror_exp = 32'h8000_0000;
`else
    ror_exp = 32'h0000_0001;
`endif
    do_start(3'b100, 1, 32'h0000_0001);
    wait_done(1, ror_exp, 2, "ror1");

    // second start mid-shift must be dropped
    do_start(3'b010, 8, 32'hF000_0000);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.shamt = 5'd2; bus.data_in = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, 32'h00F0_0000, 9, "midstart");

    // start raised while done is high: ignored that cycle, accepted next
    do_start(3'b001, 2, 32'h0000_0003);
    while (bus.done !== 1'b1) @(negedge clk);
    check("ds_data", bus.data_out, 32'h0000_000C);
    bus.start = 1'b1; bus.op = 3'b000; bus.shamt = 5'd0; bus.data_in = 32'h0000_0055;
    @(negedge clk);
    check("ds_ignored_busy", 32'(bus.busy), 32'h0);
    check("ds_ignored_data", bus.data_out, 32'h0000_000C);
    @(negedge clk);
    bus.start = 1'b0;
    check("ds_accept_done", 32'(bus.done), 32'h1);
    check("ds_accept_data", bus.data_out, 32'h0000_0055);
    @(negedge clk);

    // reset in cycle 2 of an 8-step shift aborts it
    do_start(3'b001, 8, 32'h0000_0003);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_data", bus.data_out, 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (bus.done === 1'b1) seen = 1'b1;
      end
      check("abort_no_done", 32'(seen), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data path width in bits.
REQ-002 SHALL have parameter SHAMT_W, default 5, meaning the shift amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, an operation request sampled on a clk edge.
REQ-006 SHALL have port op, input, 3, the operation code; encodings are defined in shift_pkg.
REQ-007 SHALL have port shamt, input, SHAMT_W, the shift amount.
REQ-008 SHALL have port data_in, input, WIDTH, the operand.
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port data_out, output, WIDTH, the result register.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE: latch data_in into data_out, op into op_q and shamt into counter cnt.
REQ-014 SHALL, on an accepted start with shamt != 0, go IDLE->SHIFT; with shamt == 0, go IDLE->DONE, giving a latency of 1.
REQ-015 SHALL, in SHIFT, shift data_out by exactly one bit per cycle and decrement cnt, moving to DONE on the cycle that applies the final shift (cnt == 1).
REQ-016 SHALL assert done in the DONE state only, with DONE->IDLE unconditionally, so done is high for exactly 1 cycle; for shamt = k, done is high in cycle k+1 after the start edge.
REQ-017 SHALL support op codes OP_PASS=000 (no shift), OP_SLL=001 (zero fill), OP_SRL=010 (zero fill) and OP_SRA=011 (sign bit replicated each step).
REQ-018 SHALL treat an unsupported or undefined op as OP_PASS: counts are still consumed, data_out is unchanged and timing is identical.
REQ-019 SHALL ignore start while busy; the operation in flight is not disturbed.
REQ-020 SHALL allow start in the same cycle that done is high to be ignored, since state is DONE; a new start is accepted the following cycle.
REQ-021 SHALL hold data_out stable from DONE until the next accepted start.
REQ-022 SHALL apply shamt = WIDTH-1 (31) fully: SRA of a negative value yields all ones, SLL of 1 yields 0x80000000.

Reset
REQ-023 SHALL, while reset is high at a clk edge, set state=IDLE, data_out=0, cnt=0, op_q=OP_PASS, busy=0 and done=0.
REQ-024 SHALL give reset priority over start; reset during SHIFT or DONE aborts the operation and no done pulse is produced.

Configuration
REQ-025 SHALL, with macro SHIFT_UNIT_ROTATE_EN defined, additionally support OP_ROR=100 and OP_ROL=101, rotating one bit per SHIFT cycle.
REQ-026 SHALL, without SHIFT_UNIT_ROTATE_EN, decode 100 and 101 as OP_PASS per REQ-018, with no rotate logic synthesized.

Structure
REQ-027 SHALL place the op encodings (OP_*), state encodings and default WIDTH/SHAMT_W constants in shared package shift_pkg.
REQ-028 SHALL contain one sub-module, shift_step: a combinational single-bit shift/rotate of data by op_q; the FSM and counter stay in shift_unit.

Verification
REQ-029 SHALL cover: SLL, data_in=0x00000001, shamt=4 -> done in cycle 5, data_out=0x00000010, busy high cycles 1-5.
REQ-030 SHALL cover: SRA, data_in=0x80000000, shamt=31 -> data_out=0xFFFFFFFF; SRL of the same -> 0x00000001.
REQ-031 SHALL cover: shamt=0, any op, data_in=0x1234ABCD -> done in cycle 1, data_out=0x1234ABCD.
REQ-032 SHALL cover: second start mid-SHIFT with data_in=0xFFFFFFFF -> ignored, original result and timing unchanged.
REQ-033 SHALL cover: reset asserted in cycle 2 of an shamt=8 shift -> next cycle data_out=0, busy=0, and no done pulse.
REQ-034 SHALL cover: ROR, data_in=0x00000001, shamt=1 -> 0x80000000 with SHIFT_UNIT_ROTATE_EN; 0x00000001 without it.
